// File: rtl/rca_pkg.sv
// rca_pkg: shared constants and golden reference for the ripple-carry adder.
//   RCA_DEFAULT_WIDTH : default operand width of ripple_carry_adder
//   RCA_MAX_WIDTH     : widest operand rca_ref can evaluate
//   rca_ref(a,b,cin)  : returns {carry, sum} of a+b+cin at RCA_MAX_WIDTH bits.
//                       Narrower callers zero-extend and read bit [WIDTH] as carry.
package rca_pkg;

    localparam int RCA_DEFAULT_WIDTH = 4;
    localparam int RCA_MAX_WIDTH     = 32;

    function automatic logic [RCA_MAX_WIDTH:0] rca_ref(
        input logic [RCA_MAX_WIDTH-1:0] a,
        input logic [RCA_MAX_WIDTH-1:0] b,
        input logic                     cin
    );
        return {1'b0, a} + {1'b0, b} + {{RCA_MAX_WIDTH{1'b0}}, cin};
    endfunction

endpackage

// File: rtl/full_adder.sv
// full_adder: 1-bit gate-level full adder cell.
//   a, b : operand bits
//   cin  : carry in
//   s    : sum bit
//   cout : carry out
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    // Propagate term is shared between the sum and the carry.
    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/ripple_carry_adder.sv
// ripple_carry_adder: unsigned WIDTH-bit adder built from a chain of full_adder
// cells, with combinational outputs and a registered copy of the result.
//   clk            : rising-edge clock for the registered outputs only
//   rst_n          : async active-low reset, clears the registered outputs only
//   A, B, CIN      : operands and carry into bit 0
//   SUM, CARRY     : combinational {CARRY,SUM} = A + B + CIN
//   OVF            : combinational signed overflow
//   SUM_Q, CARRY_Q,
//   OVF_Q          : the combinational results captured on every rising clk
module ripple_carry_adder
    import rca_pkg::*;
#(
    parameter int WIDTH = RCA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    output logic [WIDTH-1:0] SUM,
    output logic             CARRY,
    output logic             OVF,
    output logic [WIDTH-1:0] SUM_Q,
    output logic             CARRY_Q,
    output logic             OVF_Q
);

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] sum_d;
    logic             carry_d;
    logic             ovf_d;

    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             ovf_q;

    assign c[0] = CIN;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        full_adder u_fa (
            .a    (A[i]),
            .b    (B[i]),
            .cin  (c[i]),
            .s    (sum_d[i]),
            .cout (c[i+1])
        );
    end

    assign carry_d = c[WIDTH];
    // Two's-complement overflow: carry into the sign bit differs from carry out of it.
    assign ovf_d   = c[WIDTH] ^ c[WIDTH-1];

    assign SUM   = sum_d;
    assign CARRY = carry_d;
    assign OVF   = ovf_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    assign SUM_Q   = sum_q;
    assign CARRY_Q = carry_q;
    assign OVF_Q   = ovf_q;

endmodule

// File: tb/tb_ripple_carry_adder.sv
module tb_ripple_carry_adder;
    import rca_pkg::*;

    logic       clk;
    logic       rst_n;

    logic [3:0] a4, b4, sum4, sumq4;
    logic       cin4, carry4, ovf4, carryq4, ovfq4;

    logic [7:0] a8, b8, sum8, sumq8;
    logic       cin8, carry8, ovf8, carryq8, ovfq8;

    int tests = 0;
    int fails = 0;

    ripple_carry_adder #(.WIDTH(4)) dut4 (
        .clk     (clk),
        .rst_n   (rst_n),
        .A       (a4),
        .B       (b4),
        .CIN     (cin4),
        .SUM     (sum4),
        .CARRY   (carry4),
        .OVF     (ovf4),
        .SUM_Q   (sumq4),
        .CARRY_Q (carryq4),
        .OVF_Q   (ovfq4)
    );

    ripple_carry_adder #(.WIDTH(8)) dut8 (
        .clk     (clk),
        .rst_n   (rst_n),
        .A       (a8),
        .B       (b8),
        .CIN     (cin8),
        .SUM     (sum8),
        .CARRY   (carry8),
        .OVF     (ovf8),
        .SUM_Q   (sumq8),
        .CARRY_Q (carryq8),
        .OVF_Q   (ovfq8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic void model(input int w, input int a, input int b, input int cin,
                                  output int s, output int c, output int v);
        int tot, sa, sb, ss;
        tot = a + b + cin;
        s   = tot % (1 << w);
        c   = tot >> w;
        sa  = (a >= (1 << (w-1))) ? a - (1 << w) : a;
        sb  = (b >= (1 << (w-1))) ? b - (1 << w) : b;
        ss  = sa + sb + cin;
        v   = (ss > (1 << (w-1)) - 1 || ss < -(1 << (w-1))) ? 1 : 0;
    endfunction

    task automatic chk4(input string tag);
        int s, c, v;
        model(4, int'(a4), int'(b4), int'(cin4), s, c, v);
        chk({tag, ".sum"},   64'(sum4),   64'(s));
        chk({tag, ".carry"}, 64'(carry4), 64'(c));
        chk({tag, ".ovf"},   64'(ovf4),   64'(v));
    endtask

    initial begin
        int s, c, v;
        int es4, ec4, ev4, es8, ec8, ev8;
        logic [RCA_MAX_WIDTH:0] r;

        rst_n = 1'b0;
        a4 = '0; b4 = '0; cin4 = 1'b0;
        a8 = '0; b8 = '0; cin8 = 1'b0;
        #2;
        chk("rst.sum_q",   64'(sumq4),   64'd0);
        chk("rst.carry_q", 64'(carryq4), 64'd0);
        chk("rst.ovf_q",   64'(ovfq4),   64'd0);
        chk("rst.sum_q8",  64'(sumq8),   64'd0);

        // Exhaustive sweeps, both carry-in values.
        for (int ci = 0; ci < 2; ci++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++) begin
                    a4 = 4'(a); b4 = 4'(b); cin4 = 1'(ci);
                    #1;
                    chk(ci ? "sweep_c1.total" : "sweep_c0.total",
                        64'({carry4, sum4}), 64'(a + b + ci));
                    if (a == 15 && b == 15) chk4("sweep.ovf_max");
                end

        a4 = 4'd9; b4 = 4'd8; cin4 = 1'b0; #1;
        chk("9+8.sum", 64'(sum4), 64'd1);
        chk("9+8.carry", 64'(carry4), 64'd1);
        a4 = 4'd15; b4 = 4'd15; cin4 = 1'b1; #1;
        chk("15+15+1.sum", 64'(sum4), 64'd15);
        chk("15+15+1.carry", 64'(carry4), 64'd1);
        a4 = 4'd15; b4 = 4'd0; cin4 = 1'b1; #1;
        chk("ripple.sum", 64'(sum4), 64'd0);
        chk("ripple.carry", 64'(carry4), 64'd1);
        chk("ripple.ovf", 64'(ovf4), 64'd0);
        a4 = 4'd7; b4 = 4'd1; cin4 = 1'b0; #1;
        chk("7+1.sum", 64'(sum4), 64'd8);
        chk("7+1.carry", 64'(carry4), 64'd0);
        chk("7+1.ovf", 64'(ovf4), 64'd1);
        a8 = 8'd255; b8 = 8'd1; cin8 = 1'b0; #1;
        chk("w8.sum", 64'(sum8), 64'd0);
        chk("w8.carry", 64'(carry8), 64'd1);

        // Registers held at 0 across an edge while in reset.
        @(posedge clk); #1;
        chk("rst_hold.sum_q", 64'(sumq4), 64'd0);
        chk("rst_hold.carry_q", 64'(carryq8), 64'd0);

        @(negedge clk);
        rst_n = 1'b1;
        a4 = 4'd0; b4 = 4'd0; cin4 = 1'b0;
        @(posedge clk); #1;
        chk("lat.zero", 64'(sumq4), 64'd0);

        // Register latency.
        @(negedge clk);
        a4 = 4'd3; b4 = 4'd4; #1;
        chk("lat.comb", 64'(sum4), 64'd7);
        chk("lat.before", 64'(sumq4), 64'd0);
        @(posedge clk); #1;
        chk("lat.after", 64'(sumq4), 64'd7);
        a4 = 4'd5; b4 = 4'd6; #1;
        chk("lat2.comb", 64'(sum4), 64'd11);
        chk("lat2.before", 64'(sumq4), 64'd7);
        @(posedge clk); #1;
        chk("lat2.after", 64'(sumq4), 64'd11);

        // Async reset between edges.
        a4 = 4'd3; b4 = 4'd4;
        a8 = 8'd200; b8 = 8'd100;
        @(posedge clk); #1;
        chk("arst.pre", 64'(sumq4), 64'd7);
        chk("arst.pre_c8", 64'(carryq8), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.sum_q", 64'(sumq4), 64'd0);
        chk("arst.carry_q", 64'(carryq4), 64'd0);
        chk("arst.ovf_q", 64'(ovfq4), 64'd0);
        chk("arst.carry_q8", 64'(carryq8), 64'd0);
        a4 = 4'd2; b4 = 4'd9; #1;
        chk("arst.comb", 64'(sum4), 64'd11);
        chk("arst.sum_q_hold", 64'(sumq4), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("arst.first_cap", 64'(sumq4), 64'd11);

        // Random vectors, combinational and registered, both widths.
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            #1;
            model(4, int'(a4), int'(b4), int'(cin4), es4, ec4, ev4);
            model(8, int'(a8), int'(b8), int'(cin8), es8, ec8, ev8);
            chk4("rnd4");
            r = rca_ref(32'(a8), 32'(b8), cin8);
            chk("rnd8.ref", 64'({carry8, sum8}), 64'(r[8:0]));
            chk("rnd8.sum", 64'(sum8), 64'(es8));
            chk("rnd8.ovf", 64'(ovf8), 64'(ev8));
            @(posedge clk); #1;
            chk("rnd4.sum_q", 64'(sumq4), 64'(es4));
            chk("rnd4.carry_q", 64'(carryq4), 64'(ec4));
            chk("rnd4.ovf_q", 64'(ovfq4), 64'(ev4));
            chk("rnd8.sum_q", 64'(sumq8), 64'(es8));
            chk("rnd8.carry_q", 64'(carryq8), 64'(ec8));
            chk("rnd8.ovf_q", 64'(ovfq8), 64'(ev8));
        end

        model(4, 0, 0, 0, s, c, v);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
